// File: rtl/uart_receiver.sv
// UART receive path: 2-flop synchroniser, 16x oversampled start/data/stop deframer.
// Latency: rx_data_valid rises one clk after the stop-bit sampling tick.
// No backpressure: every byte is reported once with a one-cycle pulse.
module uart_receiver #(
  parameter int OVERSAMPLE  = 16,
  parameter int SAMPLE_TICK = 7,
  parameter int DATA_BITS   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 sck_rising_edge,
  input  logic                 sin,
  output logic                 busy,
  output logic                 rx_data_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_error
);

  localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // Tick indices pre-sized to the 4-bit tick counter so compares stay width-clean.
  localparam logic [3:0]     SAMPLE_T  = 4'(SAMPLE_TICK);
  localparam logic [3:0]     LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t               state;
  logic [3:0]           tick_cnt;
  logic [BCW-1:0]       bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 sin_m;
  logic                 sin_s;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  // It ignores en so the line state is already settled when the receiver is re-enabled.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sin_m <= 1'b1;
      sin_s <= 1'b1;
    end else begin
      sin_m <= sin;
      sin_s <= sin_m;
    end
  end

  // Frame FSM: advances only on enabled ticks; outputs are registered here.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      busy          <= 1'b0;
      rx_data_valid <= 1'b0;
      rx_data       <= '0;
      rx_error      <= 1'b0;
    end else begin
      rx_data_valid <= 1'b0;
      if (!en) begin
        // Disable wins over a coincident tick; any partial frame is dropped
        // while the last reported byte and error flag are held.
        state    <= IDLE;
        tick_cnt <= '0;
        bit_cnt  <= '0;
        busy     <= 1'b0;
      end else if (sck_rising_edge) begin
        case (state)
          IDLE: begin
            if (!sin_s) begin
              state    <= START;
              tick_cnt <= '0;
              busy     <= 1'b1;
            end
          end

          START: begin
            if (tick_cnt == SAMPLE_T && sin_s) begin
              // Line went back high before mid start bit: treat as a glitch.
              state    <= IDLE;
              tick_cnt <= '0;
              busy     <= 1'b0;
            end else if (tick_cnt == LAST_TICK) begin
              state    <= DATA;
              tick_cnt <= '0;
              bit_cnt  <= '0;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end

          DATA: begin
            // LSB arrives first, so shifting in from the top leaves bit i at position i.
            if (tick_cnt == SAMPLE_T) begin
              shreg <= {sin_s, shreg[DATA_BITS-1:1]};
            end
            if (tick_cnt == LAST_TICK) begin
              tick_cnt <= '0;
              if (bit_cnt == LAST_BIT) begin
                state <= STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end

          STOP: begin
            if (tick_cnt == SAMPLE_T) begin
              // Leave mid stop bit so a back-to-back start edge is not missed.
              rx_data       <= shreg;
              rx_error      <= ~sin_s;
              rx_data_valid <= 1'b1;
              tick_cnt      <= '0;
              bit_cnt       <= '0;
              if (sin_s) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= BRK;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end

          BRK: begin
            // A held-low line must return high before a new start can be seen.
            if (sin_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end

          default: begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: byte frames driven on sin, results checked via scoreboard.
// Tick divider of 4 clk; one bit period = 64 clk.
// DUT has no backpressure; every valid pulse must match the queue head.
module tb_uart_receiver;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       sck_rising_edge = 1'b0;
  logic       sin = 1'b1;
  logic       busy;
  logic       rx_data_valid;
  logic [7:0] rx_data;
  logic       rx_error;

  int compared = 0;
  int mismatched = 0;
  int pulses = 0;
  int div_cnt = 0;
  logic prev_vld = 1'b0;
  logic [8:0] exp_q[$];

  uart_receiver dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .sck_rising_edge(sck_rising_edge),
    .sin            (sin),
    .busy           (busy),
    .rx_data_valid  (rx_data_valid),
    .rx_data        (rx_data),
    .rx_error       (rx_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Baud divider model: one-cycle tick every 4 clk.
  initial begin
    forever begin
      @(negedge clk);
      sck_rising_edge = (div_cnt == 3);
      div_cnt = (div_cnt + 1) % 4;
    end
  end

  // Output monitor: each pulse must be one cycle wide and match the queue head.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rx_data_valid) begin
        pulses++;
        check("vld_width", {31'd0, prev_vld}, 32'd0);
        if (exp_q.size() == 0) begin
          check("vld_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rx_data", {24'd0, rx_data}, {24'd0, e[7:0]});
          check("rx_error", {31'd0, rx_error}, {31'd0, e[8]});
        end
      end
      prev_vld = rx_data_valid;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    sin = b;
    wait_clks(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    exp_q.push_back({~stop, d});
    drive_bit(1'b0);
    check("busy_in_frame", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
    check("busy_end_frame", {31'd0, busy}, {31'd0, ~stop});
  endtask

  initial begin
    logic [7:0] d;

    // Reset state
    wait_clks(4);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_vld", {31'd0, rx_data_valid}, 32'd0);
    check("rst_data", {24'd0, rx_data}, 32'd0);
    check("rst_err", {31'd0, rx_error}, 32'd0);
    rst_n = 1'b0;
    en = 1'b1;
    wait_clks(BIT_CLKS);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Single frame
    send_frame(8'hA5, 1'b1);
    wait_clks(2 * BIT_CLKS);
    check("a5_hold", {24'd0, rx_data}, 32'h0000_00A5);

    // Back-to-back frames with no idle gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    wait_clks(2 * BIT_CLKS);

    // Framing error followed by a held-low line
    send_frame(8'h3C, 1'b0);
    sin = 1'b0;
    wait_clks(40 * 4);
    check("break_busy", {31'd0, busy}, 32'd1);
    sin = 1'b1;
    wait_clks(24);
    check("break_release", {31'd0, busy}, 32'd0);
    wait_clks(2 * BIT_CLKS);

    // Short glitch: 4 ticks low
    sin = 1'b0;
    wait_clks(12);
    check("glitch_busy", {31'd0, busy}, 32'd1);
    wait_clks(4);
    sin = 1'b1;
    wait_clks(32);
    check("glitch_idle", {31'd0, busy}, 32'd0);
    wait_clks(BIT_CLKS);
    send_frame(8'h81, 1'b1);
    wait_clks(2 * BIT_CLKS);

    // Enable dropped during data bit 3
    d = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    sin = d[3];
    wait_clks(32);
    en = 1'b0;
    wait_clks(2);
    check("en_off_busy", {31'd0, busy}, 32'd0);
    check("en_off_hold", {24'd0, rx_data}, 32'h0000_0081);
    wait_clks(30);
    sin = 1'b1;
    wait_clks(2 * BIT_CLKS);
    en = 1'b1;
    wait_clks(BIT_CLKS);
    send_frame(8'h7E, 1'b1);
    wait_clks(2 * BIT_CLKS);

    // Asynchronous reset during data bit 5
    d = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 5; i++) drive_bit(d[i]);
    sin = d[5];
    wait_clks(32);
    rst_n = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_vld", {31'd0, rx_data_valid}, 32'd0);
    check("arst_data", {24'd0, rx_data}, 32'd0);
    check("arst_err", {31'd0, rx_error}, 32'd0);
    sin = 1'b1;
    wait_clks(8);
    rst_n = 1'b0;
    wait_clks(BIT_CLKS);
    send_frame(8'h12, 1'b1);

    wait_clks(2 * BIT_CLKS);
    check("queue_empty", exp_q.size(), 32'd0);
    check("pulse_count", pulses, 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Receive half of the UART core: deserialises the `sin` line into bytes, using a 16x oversampling tick (`sck_rising_edge`) supplied by the shared baud divider.
- Sits between the iomux input pin and the UART register and FIFO logic.
- Reports each byte with a one-cycle valid pulse, and flags framing errors.
- Samples each bit at the same mid-bit point that the system-test bench uses to check `sout`.

Parameters:
OVERSAMPLE, 16, sck ticks per bit period
SAMPLE_TICK, 7, tick index within a bit (0..OVERSAMPLE-1) at which `sin` is sampled
DATA_BITS, 8, data bits per frame, LSB first

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-high
en  input  1  receiver enable; low forces IDLE
sck_rising_edge  input  1  oversampling tick, one clk cycle wide, spacing >= 4 clk cycles
sin  input  1  serial input, idle high, asynchronous to clk
busy  output  1  frame reception in progress
rx_data_valid  output  1  one-cycle pulse: rx_data/rx_error updated
rx_data  output  DATA_BITS  last received byte
rx_error  output  1  framing error of last frame (stop bit sampled 0)

Behaviour:
- Reset values (rst_n=1, asynchronous):
  - `busy`=0, `rx_data_valid`=0, `rx_data`=0, `rx_error`=0.
  - State=IDLE, counters=0.
  - Both synchroniser flops=1.
- Input path: `sin` passes through a 2-flop synchroniser. All decisions use the synchronised value `sin_s`.
- Tick handling:
  - State and counters advance only on clk edges where `sck_rising_edge`=1 and `en`=1.
  - `tick_cnt` is 4 bits and wraps OVERSAMPLE-1 -> 0.
  - `bit_cnt` counts 0..DATA_BITS-1.
- State machine:
  - IDLE:
    - On a tick with `sin_s`=0: go to START, `tick_cnt`=0, `busy`=1 (registered, next cycle).
  - START:
    - At `tick_cnt`==SAMPLE_TICK with `sin_s`=1: false start. Go to IDLE, `busy`=0, no valid pulse, `rx_error` unchanged.
    - At `tick_cnt`==SAMPLE_TICK with `sin_s`=0: stay in START.
    - At `tick_cnt`==OVERSAMPLE-1: go to DATA, `bit_cnt`=0.
  - DATA:
    - At SAMPLE_TICK: shift `sin_s` into the shift register, LSB first (bit i lands at position i).
    - At OVERSAMPLE-1: if `bit_cnt`==DATA_BITS-1 go to STOP, otherwise increment `bit_cnt`.
  - STOP (at SAMPLE_TICK, the stop-bit sample):
    - `rx_data` <= shift register.
    - `rx_error` <= ~`sin_s`.
    - `rx_data_valid`=1 for exactly one clk cycle, in the cycle after the sampling edge.
    - If `sin_s`=1: go to IDLE and drop `busy`. This leaves half a bit of margin for the next start bit.
    - If `sin_s`=0: go to BREAK.
  - BREAK:
    - `busy` stays 1.
    - Wait for a tick with `sin_s`=1, then go to IDLE with `busy`=0.
    - No new start is detected while `sin_s` stays low.
- Ordering: `rx_data` and `rx_error` change only together with the `rx_data_valid` pulse, and hold otherwise.
- `en`=0 (synchronous):
  - State -> IDLE, counters cleared, `busy`=0 next cycle.
  - Any partial frame is discarded with no valid pulse.
  - `rx_data`/`rx_error` hold.
  - The synchroniser keeps running.
- Reset mid-frame: all registers return to reset values immediately. A frame in progress is lost; reception resumes on the first falling edge after reset is released.
- A tick arriving in the same cycle as `en` falling is ignored.
- A line glitch shorter than SAMPLE_TICK ticks is rejected as a false start.
- Back-to-back frames: a start bit immediately following the stop bit (a 16-tick stop) is detected with no byte lost.

Test Plan:
- Divider=4, `en`=1, frame start=0, data=0xA5 LSB first, stop=1, 16 ticks per bit -> exactly one `rx_data_valid` pulse, `rx_data`=0xA5, `rx_error`=0, `busy` high from about tick 1 of start to mid-stop.
- Back-to-back 0x00, 0xFF, 0x55 with no idle gap -> three valid pulses in order with those values, `rx_error`=0 each time.
- Frame 0x3C with stop=0, line then held low for 40 ticks, then high -> one pulse with `rx_data`=0x3C and `rx_error`=1; `busy` stays 1 until `sin` goes high; no second pulse.
- `sin` low for 4 ticks, then high -> no valid pulse; `busy` returns to 0 by tick 8; a following 0x81 frame is received correctly.
- `en` dropped during data bit 3 of a 0xC3 frame, then re-raised, then a 0x7E frame -> no pulse for 0xC3; `rx_data`=0x7E received.
- `rst_n` pulsed high during data bit 5 -> all outputs 0 asynchronously; the next frame 0x12 is received correctly.
